// File: rtl/color_filter_proc.sv
// color_filter_proc
//   Per-frame colour filter for an RGB444 pixel stream. The filter, mode and
//   test-pattern selections are sampled only on frame_start. Sampling them once
//   per frame means a button press never splits a frame between two settings.
//   Pixels that fail the filter are blanked to 12'h000. Pixels that pass are
//   counted, and the count for each frame is reported at the start of the next.
//
// Ports
//   clk, rst            clock (rising edge); async active-low reset
//   rgbfilter[2:0]      {R,G,B} component select, may change any cycle
//   rgbmode             1: RGB444 stream, 0: YUV (bypass)
//   testmode            1: camera test pattern (bypass)
//   frame_start         one-cycle pulse at the start of each frame
//   pix_in[11:0]        {R,G,B} pixel, qualified by pix_in_vld (no backpressure)
//   pix_out[11:0]       filtered pixel, qualified by pix_out_vld (2-cycle latency)
//   frame_hits          passing-pixel count of the previous frame (saturating)
//   hits_vld            one-cycle pulse when frame_hits updates
module color_filter_proc #(
    parameter logic [3:0]  c_thresh = 4'd8,
    parameter logic [3:0]  c_margin = 4'd3,
    parameter int unsigned c_cnt_w  = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         rgbfilter,
    input  logic               rgbmode,
    input  logic               testmode,
    input  logic               frame_start,
    input  logic [11:0]        pix_in,
    input  logic               pix_in_vld,
    output logic [11:0]        pix_out,
    output logic               pix_out_vld,
    output logic [c_cnt_w-1:0] frame_hits,
    output logic               hits_vld
);

    localparam logic [c_cnt_w-1:0] ACC_MAX = '1;
    localparam logic [4:0]         THR5    = {1'b0, c_thresh};
    localparam logic [4:0]         MRG5    = {1'b0, c_margin};

    // ------------------------------------------------------------------
    // Settings latch
    // ------------------------------------------------------------------
    logic [2:0] flt_act_q, flt_act_d;
    logic       rgb_act_q, rgb_act_d;
    logic       test_act_q, test_act_d;
    logic [2:0] flt_eff;
    logic       rgb_eff, test_eff;

    // A pixel that arrives with frame_start already belongs to the new frame,
    // so the incoming selections are forwarded to it directly.
    always_comb begin
        flt_act_d  = flt_act_q;
        rgb_act_d  = rgb_act_q;
        test_act_d = test_act_q;
        if (frame_start) begin
            flt_act_d  = rgbfilter;
            rgb_act_d  = rgbmode;
            test_act_d = testmode;
        end
        flt_eff  = flt_act_d;
        rgb_eff  = rgb_act_d;
        test_eff = test_act_d;
    end

    // ------------------------------------------------------------------
    // Component comparisons (stage 1 combinational)
    // ------------------------------------------------------------------
    // comp[2]=R, comp[1]=G, comp[0]=B. This order matches the rgbfilter bits.
    // Each component is zero-extended to 5 bits, so "o + margin" cannot wrap.
    logic [2:0][4:0] comp;
    logic            pass_d, byp_d;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            comp[i] = {1'b0, pix_in[4*i +: 4]};
        end
    end

    // This rule covers the single-, dual- and all-three-colour cases together.
    // Every selected component must reach the threshold. It must also exceed
    // every unselected component by the margin. With filter 111 there is no
    // unselected component, so only the threshold test remains.
    always_comb begin
        pass_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (flt_eff[i] && (comp[i] < THR5)) begin
                pass_d = 1'b0;
            end
            for (int j = 0; j < 3; j++) begin
                if ((i != j) && flt_eff[i] && !flt_eff[j] &&
                    (comp[i] < (comp[j] + MRG5))) begin
                    pass_d = 1'b0;
                end
            end
        end
        byp_d = (flt_eff == 3'b000) || !rgb_eff || test_eff;
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    // Valid and frame_start travel as two-bit shift registers.
    // Bit [1] is stage 1 and bit [2] is stage 2.
    logic [2:1]  vld_pipe_q, vld_pipe_d;
    logic [2:1]  fs_pipe_q, fs_pipe_d;
    logic [11:0] s1_pix_q, s1_pix_d;
    logic        s1_pass_q, s1_pass_d;
    logic        s1_byp_q, s1_byp_d;
    logic [11:0] pix_out_q, pix_out_d;
    logic        hit_q, hit_d;

    always_comb begin
        vld_pipe_d = {vld_pipe_q[1], pix_in_vld};
        fs_pipe_d  = {fs_pipe_q[1], frame_start};
        s1_pix_d   = pix_in;
        s1_pass_d  = pass_d;
        s1_byp_d   = byp_d;

        // pix_out holds its last value between valid pixels.
        pix_out_d = pix_out_q;
        hit_d     = 1'b0;
        if (vld_pipe_q[1]) begin
            pix_out_d = (s1_byp_q || s1_pass_q) ? s1_pix_q : 12'h000;
            hit_d     = !s1_byp_q && s1_pass_q;
        end
    end

    // ------------------------------------------------------------------
    // Hit accumulator
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] acc_q, acc_d;
    logic [c_cnt_w-1:0] frame_hits_q, frame_hits_d;
    logic               hits_vld_q, hits_vld_d;
    logic               cnt_hit;

    always_comb begin
        cnt_hit      = vld_pipe_q[2] && hit_q;
        acc_d        = acc_q;
        frame_hits_d = frame_hits_q;
        hits_vld_d   = 1'b0;
        if (fs_pipe_q[2]) begin
            // The pixel that arrived with frame_start counts toward the new frame.
            frame_hits_d = acc_q;
            hits_vld_d   = 1'b1;
            acc_d        = cnt_hit ? c_cnt_w'(1) : '0;
        end else if (cnt_hit && (acc_q != ACC_MAX)) begin
            acc_d = acc_q + c_cnt_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flt_act_q    <= 3'b000;
            rgb_act_q    <= 1'b1;
            test_act_q   <= 1'b0;
            vld_pipe_q   <= '0;
            fs_pipe_q    <= '0;
            s1_pix_q     <= '0;
            s1_pass_q    <= 1'b0;
            s1_byp_q     <= 1'b0;
            pix_out_q    <= '0;
            hit_q        <= 1'b0;
            acc_q        <= '0;
            frame_hits_q <= '0;
            hits_vld_q   <= 1'b0;
        end else begin
            flt_act_q    <= flt_act_d;
            rgb_act_q    <= rgb_act_d;
            test_act_q   <= test_act_d;
            vld_pipe_q   <= vld_pipe_d;
            fs_pipe_q    <= fs_pipe_d;
            s1_pix_q     <= s1_pix_d;
            s1_pass_q    <= s1_pass_d;
            s1_byp_q     <= s1_byp_d;
            pix_out_q    <= pix_out_d;
            hit_q        <= hit_d;
            acc_q        <= acc_d;
            frame_hits_q <= frame_hits_d;
            hits_vld_q   <= hits_vld_d;
        end
    end

    assign pix_out     = pix_out_q;
    assign pix_out_vld = vld_pipe_q[2];
    assign frame_hits  = frame_hits_q;
    assign hits_vld    = hits_vld_q;

endmodule
